// File: rtl/stopwatch_seq.sv
// Stopwatch sequencer: centisecond tick, count/clear/load strobes, preset editor
// and lap display select between the control FSM and the BCD counter datapath.
module stopwatch_seq #(
  parameter int unsigned CLK_HZ  = 100000000,
  parameter int unsigned TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        running,
  input  logic        dir,
  input  logic        clear_pulse,
  input  logic        set_btn,
  input  logic        inc_btn,
  input  logic        lap_btn,
  input  logic        cnt_zero,
  input  logic        cnt_max,
  output logic        cnt_en,
  output logic        cnt_up,
  output logic        cnt_clr,
  output logic        cnt_load,
  output logic        lap_cap,
  output logic        disp_sel,
  output logic [15:0] preset_val,
  output logic [1:0]  digit_sel,
  output logic        edit_active,
  output logic        at_zero,
  output logic        done
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EDIT,
    S_RUN,
    S_LAP,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   preset_q, preset_d;
  logic [1:0]    digit_q, digit_d;
  logic          running_q;

  logic cnt_en_q, cnt_up_q, cnt_clr_q, cnt_load_q, lap_cap_q;
  logic disp_sel_q, edit_active_q, at_zero_q, done_q;
  logic clr_d, load_d, lap_cap_d;

  logic       counting;
  logic       tick;
  logic       run_rise;
  logic       stop_at_zero;
  logic [3:0] cur_digit;
  logic [3:0] cur_limit;

  // Tens digits (1 and 3) are base-6, units digits base-10.
  function automatic logic [3:0] bump(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

  assign counting     = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick         = counting && (presc_q == PRESC_MAX);
  assign run_rise     = running && !running_q;
  assign stop_at_zero = !dir && cnt_zero;
  assign cur_digit    = preset_q[{digit_q, 2'b00} +: 4];
  assign cur_limit    = digit_q[0] ? 4'd5 : 4'd9;

  // Next-state, editor and one-shot command decode.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    preset_d  = preset_q;
    digit_d   = digit_q;
    clr_d     = 1'b0;
    load_d    = 1'b0;
    lap_cap_d = 1'b0;

    if (counting) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (run_rise) begin
          state_d = S_RUN;
        end else if (set_btn) begin
          state_d = S_EDIT;
          digit_d = 2'd0;
        end else if (clear_pulse) begin
          clr_d = 1'b1;
        end
      end
      S_EDIT: begin
        if (clear_pulse) begin
          preset_d = 16'h0000;
          digit_d  = 2'd0;
        end else begin
          if (inc_btn) begin
            preset_d[{digit_q, 2'b00} +: 4] = bump(cur_digit, cur_limit);
          end
          if (set_btn) begin
            if (digit_q == 2'd3) begin
              load_d  = 1'b1;
              state_d = S_IDLE;
              digit_d = 2'd0;
            end else begin
              digit_d = digit_q + 2'd1;
            end
          end
        end
      end
      S_RUN: begin
        if (!running) begin
          state_d = stop_at_zero ? S_DONE : S_IDLE;
        end else if (lap_btn) begin
          state_d   = S_LAP;
          lap_cap_d = 1'b1;
        end
      end
      S_LAP: begin
        if (!running) begin
          state_d = stop_at_zero ? S_DONE : S_IDLE;
        end else if (lap_btn) begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (clear_pulse) begin
          clr_d   = 1'b1;
          state_d = S_IDLE;
        end else if (set_btn) begin
          state_d = S_EDIT;
          digit_d = 2'd0;
        end else if (run_rise) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A fresh start always gets a full tick period before the first count.
    if ((state_d == S_RUN) && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      presc_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      preset_q      <= 16'h0000;
      digit_q       <= 2'd0;
      running_q     <= 1'b0;
      cnt_en_q      <= 1'b0;
      cnt_up_q      <= 1'b1;
      cnt_clr_q     <= 1'b0;
      cnt_load_q    <= 1'b0;
      lap_cap_q     <= 1'b0;
      disp_sel_q    <= 1'b0;
      edit_active_q <= 1'b0;
      at_zero_q     <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      preset_q      <= preset_d;
      digit_q       <= digit_d;
      running_q     <= running;
      cnt_en_q      <= tick && running && !(dir && cnt_max) && !stop_at_zero;
      cnt_up_q      <= dir;
      cnt_clr_q     <= clr_d;
      cnt_load_q    <= load_d;
      lap_cap_q     <= lap_cap_d;
      disp_sel_q    <= (state_d == S_LAP);
      edit_active_q <= (state_d == S_EDIT);
      at_zero_q     <= counting && stop_at_zero;
      done_q        <= (state_d == S_DONE);
    end
  end

  assign cnt_en      = cnt_en_q;
  assign cnt_up      = cnt_up_q;
  assign cnt_clr     = cnt_clr_q;
  assign cnt_load    = cnt_load_q;
  assign lap_cap     = lap_cap_q;
  assign disp_sel    = disp_sel_q;
  assign preset_val  = preset_q;
  assign digit_sel   = digit_q;
  assign edit_active = edit_active_q;
  assign at_zero     = at_zero_q;
  assign done        = done_q;

endmodule

// File: tb/tb_stopwatch_seq.sv
// Bench for stopwatch_seq: directed scenarios plus random stimulus, all checked
// every cycle against a behavioural model of the sequencer.
module tb_stopwatch_seq;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned TICK_HZ = 100;
  localparam int          DIV     = int'(CLK_HZ / TICK_HZ);

  localparam int M_IDLE = 0;
  localparam int M_EDIT = 1;
  localparam int M_RUN  = 2;
  localparam int M_LAP  = 3;
  localparam int M_DONE = 4;

  logic        clk = 1'b0;
  logic        rst_n, running, dir, clear_pulse, set_btn, inc_btn, lap_btn, cnt_zero, cnt_max;
  logic        cnt_en, cnt_up, cnt_clr, cnt_load, lap_cap, disp_sel, edit_active, at_zero, done;
  logic [15:0] preset_val;
  logic [1:0]  digit_sel;

  int n_vec = 0;
  int n_err = 0;

  // Model state: mode, four preset digits, cursor, cycles since start, last running.
  int m_mode, m_cur, m_age;
  int m_dig[4];
  bit m_prev_run;
  bit e_en, e_up, e_clr, e_load, e_lap, e_disp, e_edit, e_az, e_done;

  always #5 clk = ~clk;

  stopwatch_seq #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .running(running), .dir(dir), .clear_pulse(clear_pulse),
    .set_btn(set_btn), .inc_btn(inc_btn), .lap_btn(lap_btn), .cnt_zero(cnt_zero),
    .cnt_max(cnt_max), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_clr(cnt_clr),
    .cnt_load(cnt_load), .lap_cap(lap_cap), .disp_sel(disp_sel), .preset_val(preset_val),
    .digit_sel(digit_sel), .edit_active(edit_active), .at_zero(at_zero), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_cur = 0; m_age = 0; m_prev_run = 1'b0;
    foreach (m_dig[i]) m_dig[i] = 0;
    e_en = 0; e_up = 1; e_clr = 0; e_load = 0; e_lap = 0;
    e_disp = 0; e_edit = 0; e_az = 0; e_done = 0;
  endtask

  task automatic model_step();
    bit live, tick, rise;
    int nxt;
    live = (m_mode == M_RUN) || (m_mode == M_LAP);
    tick = live && ((m_age % DIV) == DIV - 1);
    rise = running && !m_prev_run;
    e_en = tick && running && !(dir && cnt_max) && !(!dir && cnt_zero);
    e_up = dir;
    e_az = live && !dir && cnt_zero;
    e_clr = 0; e_load = 0; e_lap = 0;
    nxt = m_mode;
    case (m_mode)
      M_IDLE: begin
        if (rise) nxt = M_RUN;
        else if (set_btn) begin nxt = M_EDIT; m_cur = 0; end
        else if (clear_pulse) e_clr = 1;
      end
      M_EDIT: begin
        if (clear_pulse) begin
          foreach (m_dig[i]) m_dig[i] = 0;
          m_cur = 0;
        end else begin
          if (inc_btn) m_dig[m_cur] = (m_dig[m_cur] + 1) % ((m_cur % 2 == 1) ? 6 : 10);
          if (set_btn) begin
            if (m_cur == 3) begin e_load = 1; nxt = M_IDLE; m_cur = 0; end
            else m_cur++;
          end
        end
      end
      M_RUN, M_LAP: begin
        if (!running) nxt = (!dir && cnt_zero) ? M_DONE : M_IDLE;
        else if (lap_btn) begin
          nxt   = (m_mode == M_RUN) ? M_LAP : M_RUN;
          e_lap = (m_mode == M_RUN);
        end
      end
      M_DONE: begin
        if (clear_pulse) begin e_clr = 1; nxt = M_IDLE; end
        else if (set_btn) begin nxt = M_EDIT; m_cur = 0; end
        else if (rise) nxt = M_RUN;
      end
      default: nxt = M_IDLE;
    endcase
    if (live) m_age++;
    if (nxt == M_RUN && (m_mode == M_IDLE || m_mode == M_DONE)) m_age = 0;
    e_disp = (nxt == M_LAP);
    e_edit = (nxt == M_EDIT);
    e_done = (nxt == M_DONE);
    m_mode = nxt;
    m_prev_run = running;
  endtask

  // Advance one clock with the inputs currently applied and check every output.
  task automatic cycle();
    int exp_pv;
    if (!rst_n) model_reset();
    else model_step();
    exp_pv = m_dig[3] * 4096 + m_dig[2] * 256 + m_dig[1] * 16 + m_dig[0];
    @(posedge clk);
    #1;
    chk("cnt_en", 32'(cnt_en), 32'(e_en));
    chk("cnt_up", 32'(cnt_up), 32'(e_up));
    chk("cnt_clr", 32'(cnt_clr), 32'(e_clr));
    chk("cnt_load", 32'(cnt_load), 32'(e_load));
    chk("lap_cap", 32'(lap_cap), 32'(e_lap));
    chk("disp_sel", 32'(disp_sel), 32'(e_disp));
    chk("edit_active", 32'(edit_active), 32'(e_edit));
    chk("at_zero", 32'(at_zero), 32'(e_az));
    chk("done", 32'(done), 32'(e_done));
    chk("preset_val", 32'(preset_val), 32'(exp_pv));
    chk("digit_sel", 32'(digit_sel), 32'(m_cur));
  endtask

  task automatic press(input bit s, input bit i, input int n);
    for (int k = 0; k < n; k++) begin
      set_btn = s; inc_btn = i;
      cycle();
      set_btn = 0; inc_btn = 0;
    end
  endtask

  task automatic run_count(input int n, output int ens);
    ens = 0;
    for (int k = 0; k < n; k++) begin
      cycle();
      if (cnt_en) ens++;
    end
  endtask

  initial begin
    int first, ens;
    rst_n = 0; running = 0; dir = 1; clear_pulse = 0; set_btn = 0; inc_btn = 0;
    lap_btn = 0; cnt_zero = 0; cnt_max = 0;

    cycle(); cycle();
    chk("rst_cnt_up", 32'(cnt_up), 32'd1);
    chk("rst_preset", 32'(preset_val), 32'd0);
    chk("rst_flags", 32'({cnt_en, cnt_clr, cnt_load, lap_cap, disp_sel, edit_active, at_zero, done}), 32'd0);
    rst_n = 1;

    // Up count: first strobe DIV cycles after entering RUN, then every DIV.
    running = 1; dir = 1;
    cycle();
    first = -1; ens = 0;
    for (int k = 1; k <= 30; k++) begin
      cycle();
      if (cnt_en) begin
        ens++;
        if (first < 0) first = k;
      end
    end
    chk("first_en_latency", 32'(first), 32'd10);
    chk("en_in_30", 32'(ens), 32'd3);

    // Lap freeze and release.
    lap_btn = 1; cycle(); lap_btn = 0;
    chk("lap_cap_pulse", 32'(lap_cap), 32'd1);
    chk("lap_disp", 32'(disp_sel), 32'd1);
    run_count(20, ens);
    chk("lap_en_in_20", 32'(ens), 32'd2);
    lap_btn = 1; cycle(); lap_btn = 0;
    chk("lap_release_disp", 32'(disp_sel), 32'd0);
    chk("lap_release_cap", 32'(lap_cap), 32'd0);

    // Up saturation.
    cnt_max = 1;
    run_count(50, ens);
    chk("sat_no_en", 32'(ens), 32'd0);
    cnt_max = 0;
    run_count(10, ens);
    chk("sat_still_run", 32'(ens), 32'd1);

    // Running falls together with lap_btn while in LAP.
    lap_btn = 1; cycle(); lap_btn = 0;
    cycle();
    running = 0; lap_btn = 1; cycle(); lap_btn = 0;
    chk("drop_lap_disp", 32'(disp_sel), 32'd0);
    chk("drop_lap_cap", 32'(lap_cap), 32'd0);

    // clear_pulse with set_btn in IDLE: set wins.
    set_btn = 1; clear_pulse = 1; cycle(); set_btn = 0; clear_pulse = 0;
    chk("idle_set_edit", 32'(edit_active), 32'd1);
    chk("idle_set_no_clr", 32'(cnt_clr), 32'd0);

    // Preset entry to 12:13.
    press(0, 1, 3); press(1, 0, 1); press(0, 1, 7);
    chk("sec_t_wrap", 32'(preset_val[7:4]), 32'd1);
    press(1, 0, 1); press(0, 1, 2); press(1, 0, 1); press(0, 1, 1); press(1, 0, 1);
    chk("preset_1213", 32'(preset_val), 32'h1213);
    chk("load_pulse", 32'(cnt_load), 32'd1);
    chk("edit_exit", 32'(edit_active), 32'd0);
    cycle();
    chk("load_single", 32'(cnt_load), 32'd0);

    // Down count to zero, DONE, then clear.
    dir = 0; running = 1;
    cycle();
    run_count(15, ens);
    cnt_zero = 1; cycle();
    chk("at_zero_set", 32'(at_zero), 32'd1);
    run_count(12, ens);
    chk("zero_no_en", 32'(ens), 32'd0);
    running = 0; cycle();
    chk("done_set", 32'(done), 32'd1);
    clear_pulse = 1; cycle(); clear_pulse = 0;
    chk("done_clr", 32'(cnt_clr), 32'd1);
    chk("done_cleared", 32'(done), 32'd0);
    cycle();
    chk("clr_single", 32'(cnt_clr), 32'd0);
    cnt_zero = 0;

    // Random traffic, including occasional mid-run resets.
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      if ($urandom_range(0, 39) == 0) running = !running;
      if ($urandom_range(0, 99) == 0) dir = !dir;
      set_btn     = ($urandom_range(0, 11) == 0);
      inc_btn     = ($urandom_range(0, 3) == 0);
      lap_btn     = ($urandom_range(0, 14) == 0);
      clear_pulse = !running && ($urandom_range(0, 9) == 0);
      cnt_zero    = ($urandom_range(0, 7) == 0);
      cnt_max     = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
